user_admit_arbiter: RTL and testbench
=====================================

# user_admit_arbiter

Admission controller for the shared subscriber pool tracked by the vodafone user-counting FSM. Several front-end channels request to join the pool; the block arbitrates them round-robin, admits up to `MAX_USERS` concurrent users, rejects requests when the pool is full, and decrements the count on release pulses. It owns the authoritative `users_count` register that downstream logic reads.

## Interface
- `N_REQ`, 4: number of requesting channels (2..8).
- `MAX_USERS`, 1000: pool capacity; requires `MAX_USERS < 2**CNT_W`.
- `CNT_W`, 10: width of `users_count`.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `req  in  N_REQ`: level join request per channel; held high until that channel sees `gnt` or `reject`, then dropped.
- `rel  in  N_REQ`: single-cycle release pulses; each set bit removes one user.
- `gnt  out  N_REQ`: one-hot admit pulse, one cycle.
- `reject  out  N_REQ`: one-hot refusal pulse, one cycle.
- `users_count  out  CNT_W`: current admitted users.
- `full  out  1`: `users_count == MAX_USERS`.
- `busy  out  1`: FSM not in IDLE.
- `rel_err  out  1`: sticky; set on an attempted release below zero.

## Operation
- FSM states are IDLE, ARB, GRANT, REJECT and HOLD.
- IDLE -> ARB when `|req`.
- ARB: select the winner `w` = first set `req` bit scanning upward from pointer `ptr`, with wrap. Register `w`.
  - If `users_count < MAX_USERS` -> GRANT, else -> REJECT.
  - If `req` went to zero in the meantime -> IDLE.
- GRANT: `gnt[w]=1`, `users_count` +1, `ptr <= (w+1) mod N_REQ`, -> HOLD.
- REJECT: `reject[w]=1`, `ptr <= (w+1) mod N_REQ`, count unchanged, -> HOLD.
- HOLD: stay while `req[w]=1`; -> IDLE when `req[w]=0`. This guarantees one decision per request assertion.
- `gnt`/`reject` are Moore outputs decoded from state and `w`; never both set, never more than one bit set.
- Releases are accepted in every state:
  - `dec = popcount(rel)`.
  - Next count = `users_count + inc - dec`, where `inc`=1 only in GRANT.
  - Computed at `CNT_W+1` bits, so simultaneous grant and release net out.
  - If the result would be negative: clamp to 0 and set `rel_err`.
- The capacity check uses the registered count, so a same-cycle release does not free space until the next ARB.
- Reset values: state IDLE, `ptr`=0, `w`=0, `users_count`=0, `rel_err`=0, `gnt`=0, `reject`=0, `full`=0, `busy`=0.

## Timing
- `req` sampled high at edge E0 -> ARB after E0 -> GRANT/REJECT after E1. `gnt`/`reject` are high for exactly the cycle between E1 and E2.
- `users_count` shows +1 after E2; `full` follows combinationally from the register.
- Minimum spacing between decisions is 4 cycles: ARB, GRANT, HOLD (`req` dropped), IDLE.
- A `rel` pulse at edge E affects `users_count` after E (1-cycle latency).
- Reset asserted mid-operation immediately clears all state and outputs, with no wait for clk. Pending requests are re-arbitrated from `ptr`=0 after release.
- On the first edge after `rst` deasserts, the block may leave IDLE.

## Configuration
- `USER_ADMIT_STATS_EN` defined:
  - Adds output `reject_count  out  16`.
  - Increments once per REJECT state and saturates at 16'hFFFF.
  - Reset 0.
- `USER_ADMIT_STATS_EN` undefined:
  - The port and counter do not exist.
  - All other behaviour is identical.

## Test plan
- Reset, then `req`=4'b0001 held until `gnt`: `gnt`=4'b0001 two cycles after the request edge, `users_count` goes 0->1; `req` dropped -> `busy`=0 within 2 cycles.
- `req`=4'b1111 held, each channel drops its `req` after its pulse and re-raises it 2 cycles later: grants in order ch0,ch1,ch2,ch3,ch0; no channel is granted twice in a row.
- `MAX_USERS`=3: four sequential requests give three `gnt` then one `reject`; `full`=1 and `users_count`=3; with the macro defined, `reject_count`=1.
- At `users_count`=3 with GRANT active, `rel`=4'b0011 in the same cycle gives `users_count`=2 next cycle.
- From `users_count`=0, `rel`=4'b0001 keeps count at 0 and sets `rel_err`=1; `rel_err` stays set until reset.
- `rst` pulled low during GRANT: `gnt`, `users_count`, `busy` and `full` read 0 before the next clk edge; after release, `req`=4'b0100 is granted normally.

Source files
------------

// File: rtl/user_admit_arbiter.sv
// user_admit_arbiter: round-robin admission control for the shared user pool.
// Channels raise a level request; the block makes one grant/reject decision per
// request assertion, keeps the authoritative users_count, and nets out release
// pulses every cycle with underflow clamping and a sticky error flag.
// Optional: define USER_ADMIT_STATS_EN to add a saturating reject_count output.
module user_admit_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_USERS = 1000,
    parameter int CNT_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] rel,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] reject,
    output logic [CNT_W-1:0] users_count,
    output logic             full,
    output logic             busy,
    output logic             rel_err
`ifdef USER_ADMIT_STATS_EN
    ,
    output logic [15:0]      reject_count
`endif
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SW = CNT_W + 1;
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_USERS);
    localparam logic [PW-1:0]    LAST_C = PW'(N_REQ - 1);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_GRANT, S_REJECT, S_HOLD} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     ptr, w, win;
    logic [SW-1:0]     dec, cnt_sum;
    logic              cnt_under;

    // Round-robin pick: scanning downward and overwriting leaves the first set
    // request found when scanning upward from ptr with wrap.
    always_comb begin
        win = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N_REQ])
                win = PW'((int'(ptr) + i) % N_REQ);
        end
    end

    // State register plus the registered winner and rotating pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            ptr   <= '0;
            w     <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_ARB)
                w <= win;
            if (state == S_GRANT || state == S_REJECT)
                ptr <= (w == LAST_C) ? '0 : w + 1'b1;
        end
    end

    // Next-state: capacity is judged on the registered count only.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (|req) state_nxt = S_ARB;
            S_ARB: begin
                if (!(|req))                state_nxt = S_IDLE;
                else if (users_count < MAX_C) state_nxt = S_GRANT;
                else                        state_nxt = S_REJECT;
            end
            S_GRANT,
            S_REJECT: state_nxt = S_HOLD;
            S_HOLD:   if (!req[w]) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from state and the registered winner.
    always_comb begin
        gnt    = '0;
        reject = '0;
        if (state == S_GRANT)  gnt[w]    = 1'b1;
        if (state == S_REJECT) reject[w] = 1'b1;
        busy = (state != S_IDLE);
    end

    // Net count change: one extra bit so grant and releases in the same cycle
    // cancel cleanly and underflow is visible as sum < dec.
    always_comb begin
        dec = '0;
        for (int i = 0; i < N_REQ; i++)
            dec = dec + SW'(rel[i]);
        cnt_sum   = {1'b0, users_count} + SW'(state == S_GRANT);
        cnt_under = (cnt_sum < dec);
    end

    // Count register with clamp-at-zero and sticky underflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            users_count <= '0;
            rel_err     <= 1'b0;
        end else begin
            users_count <= cnt_under ? '0 : CNT_W'(cnt_sum - dec);
            rel_err     <= rel_err | cnt_under;
        end
    end

    assign full = (users_count == MAX_C);

`ifdef USER_ADMIT_STATS_EN
    // Saturating count of reject decisions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            reject_count <= '0;
        else if (state == S_REJECT && reject_count != 16'hFFFF)
            reject_count <= reject_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_user_admit_arbiter.sv
// tb_user_admit_arbiter: directed + randomized checks against a transaction
// level model (round-robin pick by arithmetic, integer pool count).
module tb_user_admit_arbiter;
    localparam int N    = 4;
    localparam int MAXU = 3;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req, rel, gnt, reject;
    logic [CW-1:0] users_count;
    logic          full, busy, rel_err;
`ifdef USER_ADMIT_STATS_EN
    logic [15:0]   reject_count;
`endif

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_ptr, m_cnt, m_rej;
    bit m_err;

    always #5 clk = ~clk;

    user_admit_arbiter #(.N_REQ(N), .MAX_USERS(MAXU), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .rel         (rel),
        .gnt         (gnt),
        .reject      (reject),
        .users_count (users_count),
        .full        (full),
        .busy        (busy),
        .rel_err     (rel_err)
`ifdef USER_ADMIT_STATS_EN
        ,
        .reject_count(reject_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_ptr = 0; m_cnt = 0; m_rej = 0; m_err = 0;
    endtask

    task automatic m_rel(input int inc, input logic [N-1:0] r);
        int v;
        v = m_cnt + inc - $countones(r);
        if (v < 0) begin
            v = 0;
            m_err = 1;
        end
        m_cnt = v;
    endtask

    task automatic chk_pool(input string tag);
        chk({tag, "_cnt"},  32'(users_count), 32'(m_cnt));
        chk({tag, "_full"}, 32'(full),        32'(m_cnt == MAXU));
        chk({tag, "_err"},  32'(rel_err),     32'(m_err));
`ifdef USER_ADMIT_STATS_EN
        chk({tag, "_rejc"}, 32'(reject_count), 32'(m_rej));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; rel = '0;
        repeat (2) step();
        m_reset();
        chk("rst_gnt",  32'(gnt),    32'd0);
        chk("rst_rej",  32'(reject), 32'd0);
        chk("rst_busy", 32'(busy),   32'd0);
        chk_pool("rst");
        rst = 1'b1;
    endtask

    // Single-cycle release pulse while idle.
    task automatic rel_only(input logic [N-1:0] r);
        rel = r;
        step();
        rel = '0;
        m_rel(0, r);
        chk_pool("rel");
    endtask

    // One full decision: raise mask, optional releases during ARB and during
    // the decision cycle, then drop all requests and return to idle.
    task automatic txn(input logic [N-1:0] mask, input logic [N-1:0] rel_a,
                       input logic [N-1:0] rel_b);
        int w;
        bit g;
        logic [N-1:0] oh;
        w = -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (w < 0 && mask[k]) w = k;
        end
        g  = (m_cnt < MAXU);
        oh = '0;
        oh[w] = 1'b1;

        req = mask;
        step();                               // now ARB
        chk("arb_busy", 32'(busy),   32'd1);
        chk("arb_gnt",  32'(gnt),    32'd0);
        chk("arb_rej",  32'(reject), 32'd0);
        rel = rel_a;
        step();                               // now GRANT / REJECT
        rel = '0;
        m_rel(0, rel_a);
        chk("dec_gnt", 32'(gnt),    g ? 32'(oh) : 32'd0);
        chk("dec_rej", 32'(reject), g ? 32'd0 : 32'(oh));
        chk_pool("dec");
        req = '0;
        rel = rel_b;
        step();                               // now HOLD
        rel = '0;
        m_rel(g ? 1 : 0, rel_b);
        if (!g) m_rej++;
        m_ptr = (w + 1) % N;
        chk("hold_gnt",  32'(gnt),    32'd0);
        chk("hold_rej",  32'(reject), 32'd0);
        chk("hold_busy", 32'(busy),   32'd1);
        chk_pool("hold");
        step();                               // back to IDLE
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [N-1:0] mk, ra, rb;
        rst = 1'b0; req = '0; rel = '0;
        do_reset();

        // single requester, then all requesters rotating
        txn(4'b0001, '0, '0);
        for (int i = 0; i < 5; i++) txn(4'b1111, '0, '0);   // fills, then rejects
        // grant with a same-cycle double release nets out
        rel_only(4'b0011);                                   // 3 -> 1
        txn(4'b1111, '0, 4'b0011);                           // 1 + 1 - 2 = 0
        // release during ARB does not open capacity for this decision
        txn(4'b0010, '0, '0);
        txn(4'b0100, '0, '0);
        txn(4'b1000, '0, '0);                                // pool full
        txn(4'b0001, 4'b0001, '0);                           // still rejected

        // async reset in the middle of a GRANT
        rel_only(4'b0001);
        req = 4'b0010;
        step();
        step();
        chk("pre_rst_gnt", 32'(gnt), 32'd2);
        rst = 1'b0;
        #1;
        chk("arst_gnt",  32'(gnt),         32'd0);
        chk("arst_cnt",  32'(users_count), 32'd0);
        chk("arst_busy", 32'(busy),        32'd0);
        chk("arst_full", 32'(full),        32'd0);
        req = '0;
        step();
        step();
        rst = 1'b1;
        m_reset();
        txn(4'b0100, '0, '0);

        // underflow from 1 by two releases, then stickiness
        rel_only(4'b0011);
        rel_only(4'b0000);
        rel_only(4'b0001);

        // randomized traffic
        do_reset();
        for (int t = 0; t < 300; t++) begin
            mk = N'($urandom_range(1, (1 << N) - 1));
            ra = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            rb = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            txn(mk, ra, rb);
            if ($urandom_range(0, 4) == 0) rel_only(N'($urandom));
            if ($urandom_range(0, 40) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
